// File: rtl/instruction_fetch_if.sv
// Bus between the fetch stage, its program ROM, the execute-stage redirect and the decoder.
// The fetch stage connects through the master modport.
interface instruction_fetch_if #(
  parameter int ADDR_WIDTH  = 8,
  parameter int COUNT_WIDTH = 16
);
  logic                   en;
  logic                   mem_en;
  logic [ADDR_WIDTH-1:0]  mem_addr;
  logic [7:0]             mem_rdata;
  logic                   jump_valid;
  logic [ADDR_WIDTH-1:0]  jump_addr;
  logic [7:0]             instr_out;
  logic [ADDR_WIDTH-1:0]  instr_pc;
  logic                   instr_valid;
  logic                   instr_ready;
  logic [COUNT_WIDTH-1:0] accept_count;

  modport master (
    input  en, mem_rdata, jump_valid, jump_addr, instr_ready,
    output mem_en, mem_addr, instr_out, instr_pc, instr_valid, accept_count
  );

  modport slave (
    output en, mem_rdata, jump_valid, jump_addr, instr_ready,
    input  mem_en, mem_addr, instr_out, instr_pc, instr_valid, accept_count
  );
endinterface

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, reads a one-cycle-latency ROM, holds the instruction for the
// decoder handshake, and services jump redirects that flush any in-flight or held instruction.
module instruction_fetch #(
  parameter int                   ADDR_WIDTH  = 8,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter int                   COUNT_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  instruction_fetch_if.master   bus
);

  typedef enum logic [1:0] {IDLE, FETCH, DATA, HOLD} state_e;

  state_e                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  pc_q, pc_d;
  logic [7:0]             instrOut_q, instrOut_d;
  logic [ADDR_WIDTH-1:0]  instrPc_q, instrPc_d;
  logic                   instrValid_q, instrValid_d;
  logic [COUNT_WIDTH-1:0] acceptCount_q, acceptCount_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // A redirect overrides every other transition; en only gates the start of a new fetch.
  always_comb begin
    state_d = state_q;
    if (bus.jump_valid) begin
      state_d = bus.en ? FETCH : IDLE;
    end else begin
      case (state_q)
        IDLE:    if (bus.en) state_d = FETCH;
        FETCH:   state_d = DATA;
        DATA:    state_d = HOLD;
        HOLD:    if (bus.instr_ready) state_d = bus.en ? FETCH : IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    bus.mem_en   = (state_q == FETCH);
    bus.mem_addr = pc_q;
  end

  // Datapath next-state; a jump suppresses both capture and the handshake count.
  always_comb begin
    pc_d          = pc_q;
    instrOut_d    = instrOut_q;
    instrPc_d     = instrPc_q;
    instrValid_d  = instrValid_q;
    acceptCount_d = acceptCount_q;
    if (bus.jump_valid) begin
      pc_d         = bus.jump_addr;
      instrValid_d = 1'b0;
    end else begin
      case (state_q)
        DATA: begin
          instrOut_d   = bus.mem_rdata;
          instrPc_d    = pc_q;
          pc_d         = pc_q + ADDR_WIDTH'(1);
          instrValid_d = 1'b1;
        end
        HOLD: begin
          if (bus.instr_ready) begin
            instrValid_d  = 1'b0;
            acceptCount_d = acceptCount_q + COUNT_WIDTH'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q          <= RESET_PC;
      instrOut_q    <= '0;
      instrPc_q     <= '0;
      instrValid_q  <= 1'b0;
      acceptCount_q <= '0;
    end else begin
      pc_q          <= pc_d;
      instrOut_q    <= instrOut_d;
      instrPc_q     <= instrPc_d;
      instrValid_q  <= instrValid_d;
      acceptCount_q <= acceptCount_d;
    end
  end

  assign bus.instr_out    = instrOut_q;
  assign bus.instr_pc     = instrPc_q;
  assign bus.instr_valid  = instrValid_q;
  assign bus.accept_count = acceptCount_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: drives a behavioural ROM and the decoder handshake,
// checking each step against hand-computed values.
module tb_instruction_fetch;

  logic clk;
  logic rst;
  logic [7:0] rom [256];
  int testsRun;
  int testsFailed;

  instruction_fetch_if #(.ADDR_WIDTH(8), .COUNT_WIDTH(16)) bus ();

  instruction_fetch #(.ADDR_WIDTH(8), .RESET_PC(8'h00), .COUNT_WIDTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous ROM with one cycle of read latency.
  always @(posedge clk) begin
    if (bus.mem_en) bus.mem_rdata <= rom[bus.mem_addr];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic en, input logic ready, input logic jv, input logic [7:0] ja);
    bus.en          = en;
    bus.instr_ready = ready;
    bus.jump_valid  = jv;
    bus.jump_addr   = ja;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    for (int i = 0; i < 256; i++) rom[i] = 8'((i * 37 + 11) % 256);
    rom[8'h00] = 8'h3A;
    rom[8'h01] = 8'h5C;
    rom[8'h02] = 8'h9F;
    rom[8'h03] = 8'hC1;
    rom[8'h10] = 8'h6B;
    rom[8'h11] = 8'hD2;
    rom[8'h22] = 8'h4E;
    rom[8'hFF] = 8'hE7;

    // Reset
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    tick();
    tick();
    checkOutput("rst_valid", bus.instr_valid, 0);
    checkOutput("rst_count", bus.accept_count, 0);
    checkOutput("rst_mem_en", bus.mem_en, 0);
    checkOutput("rst_mem_addr", bus.mem_addr, 0);
    checkOutput("rst_instr_out", bus.instr_out, 0);

    // Linear fetch of ROM[0..3], decoder always ready
    rst = 1'b0;
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput("lin_fetch_mem_en", bus.mem_en, 1);
      checkOutput("lin_fetch_addr", bus.mem_addr, i);
      checkOutput("lin_fetch_valid", bus.instr_valid, 0);
      checkOutput("lin_fetch_count", bus.accept_count, i);
      tick();
      checkOutput("lin_data_mem_en", bus.mem_en, 0);
      checkOutput("lin_data_valid", bus.instr_valid, 0);
      tick();
      checkOutput("lin_hold_valid", bus.instr_valid, 1);
      checkOutput("lin_hold_out", bus.instr_out, rom[i]);
      checkOutput("lin_hold_pc", bus.instr_pc, i);
      checkOutput("lin_hold_mode", {30'b0, bus.instr_out[7:6]}, i);
    end
    tick();
    checkOutput("lin_count4", bus.accept_count, 4);
    checkOutput("lin_next_addr", bus.mem_addr, 4);

    // Backpressure on 0x5C after redirecting to address 1
    applyStimulus(1'b1, 1'b0, 1'b1, 8'h01);
    tick();
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    checkOutput("bp_fetch_addr", bus.mem_addr, 8'h01);
    checkOutput("bp_fetch_mem_en", bus.mem_en, 1);
    tick();
    tick();
    checkOutput("bp_valid", bus.instr_valid, 1);
    checkOutput("bp_out", bus.instr_out, 8'h5C);
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput("bp_stall_valid", bus.instr_valid, 1);
      checkOutput("bp_stall_out", bus.instr_out, 8'h5C);
      checkOutput("bp_stall_pc", bus.instr_pc, 8'h01);
      checkOutput("bp_stall_mem_en", bus.mem_en, 0);
      checkOutput("bp_stall_count", bus.accept_count, 4);
    end
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
    tick();
    checkOutput("bp_release_count", bus.accept_count, 5);
    checkOutput("bp_release_valid", bus.instr_valid, 0);
    checkOutput("bp_release_mem_en", bus.mem_en, 1);
    checkOutput("bp_release_addr", bus.mem_addr, 8'h02);

    // Jump during FETCH
    applyStimulus(1'b1, 1'b1, 1'b1, 8'h10);
    tick();
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
    checkOutput("jf_addr", bus.mem_addr, 8'h10);
    checkOutput("jf_mem_en", bus.mem_en, 1);
    checkOutput("jf_valid", bus.instr_valid, 0);
    tick();

    // Jump during DATA
    applyStimulus(1'b1, 1'b1, 1'b1, 8'h10);
    tick();
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
    checkOutput("jd_addr", bus.mem_addr, 8'h10);
    checkOutput("jd_mem_en", bus.mem_en, 1);
    checkOutput("jd_valid", bus.instr_valid, 0);
    tick();
    checkOutput("jd_data_valid", bus.instr_valid, 0);
    tick();
    checkOutput("jd_hold_valid", bus.instr_valid, 1);
    checkOutput("jd_hold_out", bus.instr_out, rom[8'h10]);
    checkOutput("jd_hold_pc", bus.instr_pc, 8'h10);
    checkOutput("jd_hold_count", bus.accept_count, 5);

    // Jump during HOLD with the decoder ready in the same cycle
    applyStimulus(1'b1, 1'b1, 1'b1, 8'h10);
    tick();
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
    checkOutput("jh_valid", bus.instr_valid, 0);
    checkOutput("jh_count", bus.accept_count, 5);
    checkOutput("jh_addr", bus.mem_addr, 8'h10);
    tick();
    tick();
    checkOutput("jh_hold_valid", bus.instr_valid, 1);
    checkOutput("jh_hold_out", bus.instr_out, rom[8'h10]);
    checkOutput("jh_hold_pc", bus.instr_pc, 8'h10);
    checkOutput("jh_hold_count", bus.accept_count, 5);

    // en drop while in FETCH
    tick();
    checkOutput("en_fetch_count", bus.accept_count, 6);
    checkOutput("en_fetch_addr", bus.mem_addr, 8'h11);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
    tick();
    checkOutput("en_data_mem_en", bus.mem_en, 0);
    tick();
    checkOutput("en_hold_valid", bus.instr_valid, 1);
    checkOutput("en_hold_out", bus.instr_out, rom[8'h11]);
    checkOutput("en_hold_pc", bus.instr_pc, 8'h11);
    tick();
    checkOutput("en_idle_valid", bus.instr_valid, 0);
    checkOutput("en_idle_mem_en", bus.mem_en, 0);
    checkOutput("en_idle_pc", bus.mem_addr, 8'h12);
    checkOutput("en_idle_count", bus.accept_count, 7);
    tick();
    checkOutput("en_idle2_mem_en", bus.mem_en, 0);
    checkOutput("en_idle2_valid", bus.instr_valid, 0);

    // PC wrap from 0xFF to 0x00
    applyStimulus(1'b1, 1'b1, 1'b1, 8'hFF);
    tick();
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
    checkOutput("wrap_fetch_addr", bus.mem_addr, 8'hFF);
    tick();
    tick();
    checkOutput("wrap_ff_out", bus.instr_out, rom[8'hFF]);
    checkOutput("wrap_ff_pc", bus.instr_pc, 8'hFF);
    checkOutput("wrap_ff_count", bus.accept_count, 7);
    tick();
    checkOutput("wrap_next_addr", bus.mem_addr, 8'h00);
    checkOutput("wrap_next_count", bus.accept_count, 8);
    tick();
    tick();
    checkOutput("wrap_00_out", bus.instr_out, rom[8'h00]);
    checkOutput("wrap_00_pc", bus.instr_pc, 8'h00);

    // Counter wrap from 0xFFFF
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    force dut.acceptCount_q = 16'hFFFF;
    #1;
    release dut.acceptCount_q;
    checkOutput("cnt_preset", bus.accept_count, 16'hFFFF);
    tick();
    checkOutput("cnt_hold", bus.accept_count, 16'hFFFF);
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
    tick();
    checkOutput("cnt_wrap", bus.accept_count, 16'h0000);
    checkOutput("cnt_wrap_addr", bus.mem_addr, 8'h01);

    // Reset in DATA with pc=0x22
    applyStimulus(1'b1, 1'b1, 1'b1, 8'h22);
    tick();
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
    checkOutput("rmid_fetch_addr", bus.mem_addr, 8'h22);
    tick();
    checkOutput("rmid_data_mem_en", bus.mem_en, 0);
    checkOutput("rmid_data_addr", bus.mem_addr, 8'h22);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    checkOutput("rmid_valid", bus.instr_valid, 0);
    checkOutput("rmid_addr", bus.mem_addr, 8'h00);
    checkOutput("rmid_mem_en", bus.mem_en, 0);
    checkOutput("rmid_count", bus.accept_count, 0);
    checkOutput("rmid_out", bus.instr_out, 0);
    checkOutput("rmid_pc", bus.instr_pc, 0);
    tick();
    checkOutput("rmid_idle_mem_en", bus.mem_en, 0);
    checkOutput("rmid_idle_valid", bus.instr_valid, 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Upstream fetch stage for the 8-bit instruction decoder. It owns the program counter and reads instructions from a synchronous program ROM with one cycle of read latency. It holds each fetched byte in an output register and hands it to the decoder over a valid/ready handshake. It also accepts jump redirects from the execute stage, which flush any in-flight fetch or held instruction.

## Interface
- ADDR_WIDTH, 8: program counter and ROM address width.
- RESET_PC, 0: PC value loaded on reset.
- COUNT_WIDTH, 16: width of the accepted-instruction counter.

- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- en  in  1  run enable; new fetches start only while 1.
- mem_en  out  1  ROM read strobe; 1 only in FETCH.
- mem_addr  out  ADDR_WIDTH  ROM address, always equal to the current PC.
- mem_rdata  in  8  ROM data; valid the cycle after the mem_en cycle.
- jump_valid  in  1  redirect request, one-cycle pulse.
- jump_addr  in  ADDR_WIDTH  redirect target.
- instr_out  out  8  held instruction; bits [7:6] select the decoder mode.
- instr_pc  out  ADDR_WIDTH  address that instr_out was fetched from.
- instr_valid  out  1  instr_out is valid.
- instr_ready  in  1  decoder accepts instr_out.
- accept_count  out  COUNT_WIDTH  number of completed handshakes; wraps modulo 2^COUNT_WIDTH.

## Operation
- FSM states: IDLE, FETCH, DATA, HOLD. All outputs are registered except mem_en and mem_addr, which decode from state and the PC register.
- IDLE:
  - instr_valid=0.
  - en=1 → FETCH.
- FETCH:
  - mem_en=1, mem_addr=pc.
  - → DATA unconditionally (in-flight reads always complete, regardless of en).
- DATA:
  - instr_out<=mem_rdata, instr_pc<=pc, pc<=pc+1, instr_valid<=1.
  - → HOLD.
- HOLD:
  - instr_out and instr_pc are stable while instr_valid=1.
  - instr_ready=1 is a handshake: accept_count+1, instr_valid<=0, then → FETCH if en=1, else → IDLE.
  - instr_ready=0: stay in HOLD.
- PC arithmetic: pc+1 wraps modulo 2^ADDR_WIDTH, so 0xFF → 0x00 at the default width.
- jump_valid=1 has priority over everything except rst, in any state:
  - pc<=jump_addr.
  - In FETCH or DATA, the ROM data is discarded and not captured, and pc is not incremented.
  - In HOLD, the held instruction is flushed: instr_valid<=0 and no handshake is counted, even if instr_ready=1 in the same cycle.
  - Next state is FETCH if en=1, else IDLE.
- en=0 never aborts an in-flight fetch. Only jump_valid and rst abort one.
- rst (sampled at the edge), in any state including mid-fetch:
  - pc<=RESET_PC, state<=IDLE.
  - instr_valid, instr_out, instr_pc, accept_count all <=0.
  - mem_en=0.

## Timing
- en=1 sampled in IDLE at edge N:
  - FETCH during cycle N..N+1.
  - DATA during N+1..N+2.
  - instr_valid=1 from edge N+2.
- Handshake at edge M with en=1: instr_valid=0 for cycles M..M+2, and the next instruction is valid from edge M+2.
- Steady-state throughput with instr_ready held at 1 is 1 instruction per 3 cycles.
- jump_valid at edge J with en=1: mem_en=1 with mem_addr=jump_addr in cycle J..J+1, and instr_valid=1 from J+2 carrying ROM[jump_addr].
- Reset exit with en=1 already high: the first instr_valid is seen 3 edges after the last edge at which rst=1.

## Test plan
- Reset, then linear fetch:
  - ROM[0..3]=0x3A,0x5C,0x9F,0xC1; en=1, instr_ready=1.
  - Required: instructions 0x3A,0x5C,0x9F,0xC1 with instr_pc 0..3, spaced 3 cycles apart.
  - Required: accept_count=4; decoder modes 0,1,2,3 in order.
- Backpressure:
  - Hold instr_ready=0 for 5 cycles while 0x5C is valid.
  - Required: instr_out=0x5C and instr_pc=1 stable, no new mem_en, accept_count unchanged until instr_ready=1.
- Jump in each state:
  - Pulse jump_valid with jump_addr=0x10 during FETCH, during DATA, and during HOLD with instr_ready=1.
  - Required in every case: the next valid is ROM[0x10] with instr_pc=0x10.
  - Required: the flushed instruction is never presented or counted.
- en drop:
  - Deassert en while in FETCH.
  - Required: that instruction still reaches HOLD.
  - Required: after its handshake the block goes to IDLE with mem_en=0 and pc = previous pc+1.
- Wrap:
  - jump_addr=0xFF.
  - Required: instructions from 0xFF then 0x00.
  - Set accept_count to 0xFFFF (via 65535 handshakes or force); one more handshake → 0x0000.
- Reset mid-operation:
  - Assert rst in DATA with pc=0x22.
  - Required next cycle: instr_valid=0, pc=mem_addr=RESET_PC, accept_count=0, and the ROM data is not captured.
